// File: rtl/miriscv_ctrl_pkg.sv
// Shared types and constants for the miriscv pipeline controller.
package miriscv_ctrl_pkg;

    localparam int NO_BYPASS = 0;
    localparam int NUM_CNT   = 4;

    typedef enum logic [1:0] {
        CNT_CYCLE   = 2'd0,
        CNT_INSTR   = 2'd1,
        CNT_MISPRED = 2'd2,
        CNT_STALL   = 2'd3
    } cnt_sel_t;

    // Width of a bypass select: 0 = register file, k+1 = producer k.
    function automatic int byp_sel_w(input int num_byp);
        return $clog2(num_byp + 1);
    endfunction

endpackage

// File: rtl/miriscv_perf_counters.sv
// Four free-running performance counters with clear/freeze and a registered
// readout that shows the selected counter as it was before this cycle's update.
module miriscv_perf_counters
    import miriscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [NUM_CNT-1:0] inc_i,
    input  cnt_sel_t           sel_i,
    input  logic               clear_i,
    input  logic               freeze_i,
    output logic [CNT_W-1:0]   rdata_o
);

    logic [CNT_W-1:0] cnt_q [NUM_CNT];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            // NOTE: four flops per bit, not a RAM macro, so an async reset of the whole array is fine.
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            rdata_o <= '0;
        end else begin
            rdata_o <= cnt_q[sel_i];
            for (int i = 0; i < NUM_CNT; i++) begin
                if (clear_i)
                    cnt_q[i] <= '0;
                else if (!freeze_i && inc_i[i])
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// Pipeline control for the miriscv core: hazards/bypass, cascaded stalls,
// redirect arbitration with a pending hold, and performance counters.
module miriscv_pipe_ctrl
    import miriscv_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int GPR_ADDR_W     = 5,
    parameter int NUM_STAGES     = 5,
    parameter int NUM_BYP        = 3,
    parameter int LOAD_USE_DEPTH = 3,
    parameter int BOOT_CYCLES    = 2,
    parameter int CNT_W          = 64,
    localparam int BYP_SEL_W     = byp_sel_w(NUM_BYP)
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [XLEN-1:0]               boot_addr_i,
    input  logic [NUM_STAGES-1:0]         stall_req_i,
    input  logic [NUM_STAGES-1:0]         valid_i,
    input  logic [GPR_ADDR_W-1:0]         rs1_addr_i,
    input  logic [GPR_ADDR_W-1:0]         rs2_addr_i,
    input  logic                          rs1_req_i,
    input  logic                          rs2_req_i,
    input  logic [NUM_BYP*GPR_ADDR_W-1:0] prod_rd_addr_i,
    input  logic [NUM_BYP-1:0]            prod_rd_we_i,
    input  logic [NUM_BYP-1:0]            prod_load_i,
    input  logic                          mp_prediction_i,
    input  logic                          mp_br_j_taken_i,
    input  logic [XLEN-1:0]               mp_target_pc_i,
    input  logic [XLEN-1:0]               mp_next_pc_i,
    input  logic                          ext_redirect_i,
    input  logic [XLEN-1:0]               ext_redirect_pc_i,
    input  logic                          force_rdy_i,
    input  logic [1:0]                    cnt_sel_i,
    input  logic                          cnt_clear_i,
    input  logic                          cnt_freeze_i,
    output logic [BYP_SEL_W-1:0]          byp_sel1_o,
    output logic [BYP_SEL_W-1:0]          byp_sel2_o,
    output logic [NUM_STAGES-1:0]         stall_o,
    output logic [NUM_STAGES-1:0]         kill_o,
    output logic [XLEN-1:0]               force_pc_o,
    output logic                          force_f_o,
    output logic [CNT_W-1:0]              cnt_rdata_o
);

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

    logic [NUM_BYP-1:0] haz1, haz2;
    logic               load_stall;

    for (genvar k = 0; k < NUM_BYP; k++) begin : g_haz
        logic [GPR_ADDR_W-1:0] rd;
        logic                  live;
        assign rd      = prod_rd_addr_i[k*GPR_ADDR_W +: GPR_ADDR_W];
        assign live    = valid_i[0] & prod_rd_we_i[k] & valid_i[k+1] & (rd != '0);
        assign haz1[k] = live & rs1_req_i & (rs1_addr_i == rd);
        assign haz2[k] = live & rs2_req_i & (rs2_addr_i == rd);
    end

    always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        byp_sel1_o = BYP_SEL_W'(NO_BYPASS);
        byp_sel2_o = BYP_SEL_W'(NO_BYPASS);
        // NOTE: blocking '=' walking from oldest to youngest makes the lowest k, written last, win.
        for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (haz1[k]) byp_sel1_o = BYP_SEL_W'(k + 1);
            if (haz2[k]) byp_sel2_o = BYP_SEL_W'(k + 1);
        end
    end

    // Only the youngest producers' load data is not yet available for forwarding.
    always_comb begin
        load_stall = 1'b0;
        for (int k = 0; k < LOAD_USE_DEPTH; k++)
            load_stall = load_stall | ((haz1[k] | haz2[k]) & prod_load_i[k]);
    end

    // A stall in stage j holds every younger stage i < j.
    always_comb begin
        stall_o = '0;
        stall_o[NUM_STAGES-1] = stall_req_i[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--)
            stall_o[i] = stall_o[i+1] | stall_req_i[i];
        stall_o[0] = stall_o[0] | load_stall;
    end

    logic [BOOT_W-1:0] boot_cnt_q;
    logic              boot_en;

    assign boot_en = boot_cnt_q < BOOT_W'(BOOT_CYCLES);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)
            boot_cnt_q <= '0;
        else if (boot_en)
            boot_cnt_q <= boot_cnt_q + BOOT_W'(1);
    end

    logic            mispredict, redirect_evt, pending_q;
    logic [XLEN-1:0] mp_pc, evt_pc, pend_pc_q;
    logic [NUM_STAGES-1:0] kill_raw;

    assign mispredict   = valid_i[NUM_STAGES-1] & (mp_prediction_i ^ mp_br_j_taken_i);
    assign mp_pc        = mp_br_j_taken_i ? mp_target_pc_i : mp_next_pc_i;
    assign redirect_evt = ext_redirect_i | mispredict;
    assign evt_pc       = ext_redirect_i ? ext_redirect_pc_i : mp_pc;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pending_q <= 1'b0;
            pend_pc_q <= '0;
        end else if (redirect_evt && !boot_en && !force_rdy_i) begin
            pending_q <= 1'b1;
            pend_pc_q <= evt_pc;
        end else if (force_rdy_i) begin
            pending_q <= 1'b0;
        end
    end

    assign force_f_o  = boot_en | redirect_evt | pending_q;
    assign force_pc_o = boot_en      ? boot_addr_i :
                        redirect_evt ? evt_pc      : pend_pc_q;

    // While a redirect waits for fetch, only the fetch stage is flushed each cycle.
    assign kill_raw = redirect_evt ? '1 : {{(NUM_STAGES-1){1'b0}}, pending_q};
    assign kill_o   = arstn_i ? kill_raw : '0;

    logic [NUM_CNT-1:0] perf_inc;

    assign perf_inc[CNT_CYCLE]   = 1'b1;
    assign perf_inc[CNT_INSTR]   = valid_i[NUM_STAGES-1] & ~stall_o[NUM_STAGES-1];
    assign perf_inc[CNT_MISPRED] = mispredict;
    assign perf_inc[CNT_STALL]   = stall_o[0];

    miriscv_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .inc_i    (perf_inc),
        .sel_i    (cnt_sel_t'(cnt_sel_i)),
        .clear_i  (cnt_clear_i),
        .freeze_i (cnt_freeze_i),
        .rdata_o  (cnt_rdata_o)
    );

endmodule

// File: tb/tb_miriscv_pipe_ctrl.sv
// Self-checking bench for miriscv_pipe_ctrl: constant checks on the combinational
// paths and a scoreboard of counter readouts for a 64-bit and a 4-bit instance.
module tb_miriscv_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [31:0] boot_addr_i;
    logic [4:0]  stall_req_i, valid_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic        rs1_req_i, rs2_req_i;
    logic [14:0] prod_rd_addr_i;
    logic [2:0]  prod_rd_we_i, prod_load_i;
    logic        mp_prediction_i, mp_br_j_taken_i;
    logic [31:0] mp_target_pc_i, mp_next_pc_i;
    logic        ext_redirect_i;
    logic [31:0] ext_redirect_pc_i;
    logic        force_rdy_i;
    logic [1:0]  cnt_sel_i;
    logic        cnt_clear_i, cnt_freeze_i;

    logic [1:0]  byp1, byp2, byp1_4, byp2_4;
    logic [4:0]  stall, kill, stall_4, kill_4;
    logic [31:0] fpc, fpc_4;
    logic        ff, ff_4;
    logic [63:0] rdata64;
    logic [3:0]  rdata4;

    always #5 clk_i = ~clk_i;

    miriscv_pipe_ctrl u_dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .boot_addr_i(boot_addr_i),
        .stall_req_i(stall_req_i), .valid_i(valid_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_req_i(rs1_req_i), .rs2_req_i(rs2_req_i),
        .prod_rd_addr_i(prod_rd_addr_i), .prod_rd_we_i(prod_rd_we_i), .prod_load_i(prod_load_i),
        .mp_prediction_i(mp_prediction_i), .mp_br_j_taken_i(mp_br_j_taken_i),
        .mp_target_pc_i(mp_target_pc_i), .mp_next_pc_i(mp_next_pc_i),
        .ext_redirect_i(ext_redirect_i), .ext_redirect_pc_i(ext_redirect_pc_i),
        .force_rdy_i(force_rdy_i), .cnt_sel_i(cnt_sel_i),
        .cnt_clear_i(cnt_clear_i), .cnt_freeze_i(cnt_freeze_i),
        .byp_sel1_o(byp1), .byp_sel2_o(byp2), .stall_o(stall), .kill_o(kill),
        .force_pc_o(fpc), .force_f_o(ff), .cnt_rdata_o(rdata64)
    );

    miriscv_pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk_i), .arstn_i(arstn_i), .boot_addr_i(boot_addr_i),
        .stall_req_i(stall_req_i), .valid_i(valid_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_req_i(rs1_req_i), .rs2_req_i(rs2_req_i),
        .prod_rd_addr_i(prod_rd_addr_i), .prod_rd_we_i(prod_rd_we_i), .prod_load_i(prod_load_i),
        .mp_prediction_i(mp_prediction_i), .mp_br_j_taken_i(mp_br_j_taken_i),
        .mp_target_pc_i(mp_target_pc_i), .mp_next_pc_i(mp_next_pc_i),
        .ext_redirect_i(ext_redirect_i), .ext_redirect_pc_i(ext_redirect_pc_i),
        .force_rdy_i(force_rdy_i), .cnt_sel_i(cnt_sel_i),
        .cnt_clear_i(cnt_clear_i), .cnt_freeze_i(cnt_freeze_i),
        .byp_sel1_o(byp1_4), .byp_sel2_o(byp2_4), .stall_o(stall_4), .kill_o(kill_4),
        .force_pc_o(fpc_4), .force_f_o(ff_4), .cnt_rdata_o(rdata4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [63:0] exp;
        bit          narrow;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] m64 [4];
    logic [3:0]  m4  [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m64[i] = '0;
            m4[i]  = '0;
        end
        sb_q.delete();
    endtask

    // One clock: push the readout the DUTs must show after this edge, advance the
    // counter model, then pop and compare against both instances.
    task automatic tick();
        sb_t        e;
        logic [3:0] inc;
        e.tag = "rdata64"; e.exp = m64[cnt_sel_i];         e.narrow = 1'b0; sb_q.push_back(e);
        e.tag = "rdata4";  e.exp = {60'd0, m4[cnt_sel_i]}; e.narrow = 1'b1; sb_q.push_back(e);
        inc[0] = 1'b1;
        inc[1] = valid_i[4] & ~stall_req_i[4];
        inc[2] = valid_i[4] & (mp_prediction_i ^ mp_br_j_taken_i);
        inc[3] = |stall_req_i;
        for (int i = 0; i < 4; i++) begin
            if (cnt_clear_i) begin
                m64[i] = '0;
                m4[i]  = '0;
            end else if (!cnt_freeze_i && inc[i]) begin
                m64[i] = m64[i] + 64'd1;
                m4[i]  = m4[i] + 4'd1;
            end
        end
        @(posedge clk_i);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, e.narrow ? {60'd0, rdata4} : rdata64, e.exp);
        end
    endtask

    task automatic idle_inputs();
        stall_req_i = '0; valid_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rs1_req_i = 1'b0; rs2_req_i = 1'b0;
        prod_rd_addr_i = '0; prod_rd_we_i = '0; prod_load_i = '0;
        mp_prediction_i = 1'b0; mp_br_j_taken_i = 1'b0;
        mp_target_pc_i = '0; mp_next_pc_i = '0;
        ext_redirect_i = 1'b0; ext_redirect_pc_i = '0;
    endtask

    // Asserts reset between edges with a redirect on the inputs, then checks boot forcing.
    task automatic do_reset(input logic [31:0] baddr);
        boot_addr_i       = baddr;
        ext_redirect_i    = 1'b1;
        ext_redirect_pc_i = 32'h0000_0BAD;
        valid_i           = 5'b10000;
        mp_br_j_taken_i   = 1'b1;
        arstn_i           = 1'b0;
        #1;
        model_reset();
        check("rst_force_f",  64'(ff),    64'd1);
        check("rst_force_pc", 64'(fpc),   64'(baddr));
        check("rst_kill",     64'(kill),  64'd0);
        check("rst_rdata",    rdata64,    64'd0);
        check("rst_rdata4",   64'(rdata4), 64'd0);
        check("rst_force_f4", 64'(ff_4),  64'd1);
        check("rst_force_pc4", 64'(fpc_4), 64'(baddr));
        check("rst_kill4",    64'(kill_4), 64'd0);
        @(posedge clk_i);
        #1;
        idle_inputs();
        arstn_i = 1'b1;
        #1;
        check("boot0_f",  64'(ff),  64'd1);
        check("boot0_pc", 64'(fpc), 64'(baddr));
        tick();
        check("boot1_f",  64'(ff),  64'd1);
        check("boot1_pc", 64'(fpc), 64'(baddr));
        tick();
        check("boot_done_f", 64'(ff), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn_i = 1'b1;
        boot_addr_i = '0;
        force_rdy_i = 1'b1;
        cnt_sel_i = 2'd0; cnt_clear_i = 1'b0; cnt_freeze_i = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        do_reset(32'h8000_0000);

        // Counter freeze and clear-over-freeze.
        cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
        repeat (10) tick();
        cnt_freeze_i = 1'b1;
        repeat (5) tick();
        cnt_sel_i = 2'd0;
        tick();
        check("frz_rdata", rdata64, 64'd10);
        cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
        tick();
        check("clr_frz_rdata", rdata64, 64'd0);
        cnt_freeze_i = 1'b0;

        // 4-bit instance wraps 15 -> 0.
        cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
        repeat (15) tick();
        tick();
        check("wrap_pre", 64'(rdata4), 64'd15);
        tick();
        check("wrap_zero", 64'(rdata4), 64'd0);

        // Bypass: producers 0 and 2 both write x5.
        valid_i = 5'b01011; prod_rd_we_i = 3'b101;
        prod_rd_addr_i = {5'd5, 5'd9, 5'd5};
        rs1_addr_i = 5'd5; rs1_req_i = 1'b1; rs2_addr_i = 5'd3; rs2_req_i = 1'b1;
        #1;
        check("byp_youngest", 64'(byp1),   64'd1);
        check("byp_youngest4", 64'(byp1_4), 64'd1);
        check("byp_rs2_none", 64'(byp2),   64'd0);
        check("byp_no_stall", 64'(stall),  64'd0);
        prod_rd_we_i = 3'b100; #1;
        check("byp_oldest", 64'(byp1), 64'd3);
        valid_i = 5'b00011; #1;
        check("byp_invalid_prod", 64'(byp1), 64'd0);
        valid_i = 5'b01011; rs1_req_i = 1'b0; #1;
        check("byp_no_req", 64'(byp1), 64'd0);
        rs1_req_i = 1'b1; prod_rd_we_i = 3'b101;
        prod_rd_addr_i = {5'd0, 5'd9, 5'd0}; rs1_addr_i = 5'd0; #1;
        check("byp_x0", 64'(byp1), 64'd0);

        // Load-use on producer 1.
        idle_inputs();
        valid_i = 5'b00101; prod_rd_we_i = 3'b010; prod_load_i = 3'b010;
        prod_rd_addr_i = {5'd0, 5'd7, 5'd0};
        rs2_addr_i = 5'd7; rs2_req_i = 1'b1; rs1_addr_i = 5'd1; rs1_req_i = 1'b1;
        #1;
        check("lu_stall",  64'(stall),   64'h01);
        check("lu_stall4", 64'(stall_4), 64'h01);
        check("lu_byp2",   64'(byp2),    64'd2);
        check("lu_byp2_4", 64'(byp2_4),  64'd2);
        check("lu_byp1",   64'(byp1),    64'd0);
        stall_req_i = 5'b01000; #1;
        check("lu_cascade", 64'(stall), 64'h0F);
        stall_req_i = '0; valid_i = 5'b00100; #1;
        check("lu_no_consumer", 64'(stall), 64'd0);
        idle_inputs();

        // Instruction and stall counters with a retiring last stage.
        cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
        valid_i = 5'b10000; mp_prediction_i = 1'b1; mp_br_j_taken_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stall_req_i = i[0] ? 5'b10000 : 5'b00010;
            tick();
        end
        stall_req_i = '0;
        cnt_sel_i = 2'd1; tick();
        cnt_sel_i = 2'd3; tick();
        cnt_sel_i = 2'd2; tick();
        idle_inputs();
        cnt_sel_i = 2'd0;

        // Mispredict with fetch not ready for three cycles.
        force_rdy_i = 1'b0;
        valid_i = 5'b10000; mp_prediction_i = 1'b0; mp_br_j_taken_i = 1'b1;
        mp_target_pc_i = 32'h100; mp_next_pc_i = 32'h104;
        #1;
        check("mp_kill_all", 64'(kill), 64'h1F);
        check("mp_force_f",  64'(ff),   64'd1);
        check("mp_force_pc", 64'(fpc),  64'h100);
        tick();
        valid_i = '0; #1;
        for (int i = 0; i < 2; i++) begin
            check("pend_force_f",  64'(ff),   64'd1);
            check("pend_force_pc", 64'(fpc),  64'h100);
            check("pend_kill",     64'(kill), 64'h01);
            tick();
        end
        force_rdy_i = 1'b1; #1;
        check("pend_last_f", 64'(ff), 64'd1);
        tick();
        check("pend_clr_f",    64'(ff),   64'd0);
        check("pend_clr_kill", 64'(kill), 64'd0);

        // New event while pending overwrites the held target.
        force_rdy_i = 1'b0; ext_redirect_i = 1'b1; ext_redirect_pc_i = 32'h300; #1;
        tick();
        ext_redirect_pc_i = 32'h340; #1;
        check("ovr_event_pc", 64'(fpc), 64'h340);
        tick();
        ext_redirect_i = 1'b0; #1;
        check("ovr_pend_pc", 64'(fpc), 64'h340);
        force_rdy_i = 1'b1; tick();
        check("ovr_clr_f", 64'(ff), 64'd0);

        // External redirect beats a simultaneous mispredict; the mispredict still counts.
        cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
        valid_i = 5'b10000; mp_prediction_i = 1'b0; mp_br_j_taken_i = 1'b1;
        mp_target_pc_i = 32'h100; ext_redirect_i = 1'b1; ext_redirect_pc_i = 32'h200;
        #1;
        check("ext_pc",   64'(fpc),  64'h200);
        check("ext_kill", 64'(kill), 64'h1F);
        tick();
        idle_inputs();
        cnt_sel_i = 2'd2;
        tick();
        check("mis_cnt", rdata64, 64'd1);
        cnt_sel_i = 2'd0;

        // Reset while a redirect is pending: pending must not survive.
        force_rdy_i = 1'b0; ext_redirect_i = 1'b1; ext_redirect_pc_i = 32'h400; #1;
        tick();
        ext_redirect_i = 1'b0; #1;
        check("pre_rst_pend", 64'(ff), 64'd1);
        do_reset(32'h0000_1000);
        check("post_rst_kill", 64'(kill), 64'd0);
        force_rdy_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
